// File: rtl/serial_adder_pkg.sv
// serial_adder shared definitions.
// State encodings and default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder request/result bundle.
// The master issues operands; the slave returns the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/half_adder.sv
// One-bit half adder.
// Upstream combinational stage of serial_adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder from two half adders.
// Datapath of the bit-serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (w_s1),
    .cout (w_c1)
  );

  half_adder u_ha1 (
    .a    (w_s1),
    .b    (cin),
    .sum  (sum),
    .cout (w_c2)
  );

  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first.
// One bit per clock; result registered at completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_nx;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New bit enters at the MSB so the LSB lands at bit 0 last.
  assign w_psum_nx = (r_psum >> 1)
                   | {w_s, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_RUN);
      r_done  <= (w_next == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_psum  <= w_psum_nx;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_psum_nx;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive bench for serial_adder.
// WIDTH=8 vectors and corners, WIDTH=4 exhaustive.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8();
  serial_adder_if #(.WIDTH(4)) bus4();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t       vecs [8];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] prev_sum = 8'h00;
  logic       prev_co = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [32:0] act,
                       input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally disturbs inputs mid-run
  // and pulses start during the DONE cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es,
                      input logic eco, input bit disturb);
    bus8.a = a;
    bus8.b = b;
    bus8.cin = ci;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("busy_e0", bus8.busy, 1);
    check("done_e0", bus8.done, 0);
    for (int k = 1; k < 8; k++) begin
      if (disturb && k == 2) begin
        bus8.start = 1'b1;
        bus8.a = ~a;
        bus8.b = ~b;
        bus8.cin = ~ci;
      end
      if (disturb && k == 5) bus8.start = 1'b0;
      tick();
      check("busy_run", bus8.busy, 1);
      check("done_run", bus8.done, 0);
      check("sum_hold", bus8.sum, prev_sum);
      check("cout_hold", bus8.cout, prev_co);
    end
    tick();
    check("busy_end", bus8.busy, 0);
    check("done_end", bus8.done, 1);
    check("sum", bus8.sum, es);
    check("cout", bus8.cout, eco);
    if (disturb) bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("done_clr", bus8.done, 0);
    check("busy_idle", bus8.busy, 0);
    if (disturb) begin
      tick();
      check("no_restart", bus8.busy, 0);
      check("sum_keep", bus8.sum, es);
    end
    prev_sum = es;
    prev_co = eco;
  endtask

  initial begin
    logic [8:0] ref5;
    logic [8:0] nx;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.cin = 1'b0;

    // Reset with start asserted and random operands.
    rst = 1'b1;
    bus8.start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      bus8.cin = 1'($urandom);
      tick();
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_sum", bus8.sum, 0);
      check("rst_cout", bus8.cout, 0);
    end
    bus8.start = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_busy", bus8.busy, 0);

    for (int i = 0; i < 8; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cin,
           vecs[i].s, vecs[i].co, 1'b0);

    // Inputs and start disturbed while running.
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);

    // Reset three edges after the start edge.
    bus8.a = 8'hFF;
    bus8.b = 8'hFF;
    bus8.cin = 1'b1;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_sum", bus8.sum, 0);
    check("abort_cout", bus8.cout, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_no_done", bus8.done, 0);
      check("abort_idle", bus8.busy, 0);
    end
    prev_sum = 8'h00;
    prev_co = 1'b0;
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Start held high: second op accepted WIDTH+2 edges later.
    bus8.a = 8'h01;
    bus8.b = 8'h02;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    tick();
    check("hold_acc0", bus8.busy, 1);
    bus8.a = 8'h10;
    bus8.b = 8'h20;
    for (int k = 0; k < 8; k++) tick();
    check("hold_done0", bus8.done, 1);
    check("hold_sum0", bus8.sum, 8'h03);
    tick();
    check("hold_gap", bus8.busy, 0);
    tick();
    check("hold_acc1", bus8.busy, 1);
    bus8.start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("hold_done1", bus8.done, 1);
    check("hold_sum1", bus8.sum, 8'h30);
    tick();

    // WIDTH=4 exhaustive, start held high throughout.
    nx = 9'd0;
    bus4.a = nx[3:0];
    bus4.b = nx[7:4];
    bus4.cin = nx[8];
    bus4.start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      nx = 9'(i);
      ref5 = 9'({1'b0, nx[3:0]} + {1'b0, nx[7:4]} + 5'(nx[8]));
      tick();
      check("ex_accept", bus4.busy, 1);
      nx = 9'(i + 1);
      bus4.a = nx[3:0];
      bus4.b = nx[7:4];
      bus4.cin = nx[8];
      for (int k = 1; k < 4; k++) begin
        tick();
        check("ex_nodone", bus4.done, 0);
      end
      tick();
      check("ex_done", bus4.done, 1);
      check("ex_sum", bus4.sum, ref5[3:0]);
      check("ex_cout", bus4.cout, ref5[4]);
      tick();
      check("ex_gap", bus4.busy, 0);
    end
    bus4.start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
